uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

UART serial receiver paired with the existing Tx unit; the two share the same `parity_type` and `baud_rate` encodings. Oversamples `data_rx` at 16x the selected baud rate and detects a start bit on a falling edge. Samples each bit at mid-period, checks parity and stop bit, then presents the received byte with a one-cycle `done_flag` pulse. Sits at the receive pin of the UART, in parallel with the transmit path.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `clock` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `parity_type` input 2: 00 = no parity, 01 = odd, 10 = even, 11 = no parity.
- `baud_rate` input 2: 00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
- `data_rx` input 1: serial line; idles high; asynchronous to `clock`.
- `data_out` output 8: last received byte; held until the next frame completes.
- `active_flag` output 1: high while a frame is being received.
- `done_flag` output 1: one-cycle pulse at the end of each frame.
- `parity_error` output 1: parity mismatch in the last frame; valid with `done_flag`, then held.
- `frame_error` output 1: stop bit sampled as 0 in the last frame; valid with `done_flag`, then held.

## Operation
- Input stage:
  - `data_rx` is registered to `rx_s` (see Configuration).
  - `rx_prev` is a delayed copy of `rx_s`; it resets to 1.
  - A start edge is `rx_prev`=1 and `rx_s`=0.
- Tick generator:
  - `DIV = CLK_FREQ / (16*baud)`, integer truncation; the four values are computed at elaboration.
  - 16-bit counter runs 0..DIV-1 and emits `tick` when it equals DIV-1.
  - Counter is held at 0 in IDLE, so the tick phase aligns to the start edge.
  - `DIV` < 2 is unsupported.
- Frame latching: `baud_rate` and `parity_type` are latched on the start edge and are constant for the rest of the frame.
- State machine:
  - **IDLE**: `active_flag`=0. On a start edge, go to START and clear the tick counter and the tick-count nibble.
  - **START**: on the 8th tick, sample `rx_s`.
    - If 1 (false start): return to IDLE; no `done_flag`; error flags unchanged.
    - If 0: go to DATA, bit index 0.
  - **DATA**: every 16th tick, sample `rx_s` into the shift register, LSB first.
    - After bit 7, go to PARITY if the latched parity is 01 or 10; otherwise go to STOP.
  - **PARITY**: sample after 16 ticks.
    - Error if the XOR of the 8 data bits and the parity bit is 0 for odd parity, or 1 for even parity.
  - **STOP**: sample after 16 ticks, then go to DONE.
  - **DONE**: single cycle, then IDLE.
    - Assert `done_flag`.
    - Load `data_out` from the shift register.
    - Load `parity_error` (forced to 0 when no parity) and `frame_error` (= not stop sample).
- On a frame error the byte is still delivered with `done_flag`.
- After a frame, a new start needs a fresh 1-to-0 edge. A line held low after a frame error is not re-received until it returns high.
- Reset, at any time including mid-frame:
  - State to IDLE; counters to 0; `rx_prev`=1.
  - `data_out`=0x00; `active_flag`, `done_flag`, `parity_error`, `frame_error` all 0.
  - The partial frame is discarded.

## Timing
- Cycle numbering: cycle E is the first cycle with `rx_s`=0 and `rx_prev`=1.
- `active_flag` rises at E+1.
- Tick k (k≥1) occurs at E + k·DIV.
- Sampling points:
  - Start sample: tick 8.
  - Data bit n (n = 0..7): tick 24 + 16n.
  - Parity: tick 152.
  - Stop: tick 152 without parity, tick 168 with parity.
- `done_flag` is high exactly one cycle, on the cycle after the stop sample.
  - `data_out` and the error flags update on that same cycle.
- `active_flag` falls on the cycle after `done_flag`.
- Input latency from `data_rx` to `rx_s`: 1 clock, or 2 with `UART_RX_SYNC2_EN`. All offsets above are relative to `rx_s`.
- Back-to-back frames are supported: a start edge immediately after the stop bit is accepted once the FSM is in IDLE.

## Configuration
- Macro: `UART_RX_SYNC2_EN`.
- Defined: `data_rx` passes through a two-flop synchronizer to `rx_s` (2-cycle latency). Required when the line is truly asynchronous.
- Undefined: a single register stage (1-cycle latency). Only for benches and synchronous loopback.

## Test plan
Bench setup for all cases: `CLK_FREQ`=614_400, so DIV = 16, 8, 4, 2 for codes 00, 01, 10, 11. Bit period = 16·DIV clocks.
- Reset, then idle high for 1000 cycles -> all outputs 0, no `done_flag`.
- `baud_rate`=00, `parity_type`=00, send 0xA5 with stop 1 -> `done_flag` exactly at E+152·16+1; `data_out`=0xA5; both errors 0.
- `parity_type`=01, send 0x03 with parity bit 1, then again with parity bit 0 -> first frame `parity_error`=0, second `parity_error`=1. `data_out`=0x03 both times.
- `baud_rate`=11, `parity_type`=10, send 0xFF with parity 0 and stop 0 -> `frame_error`=1, `parity_error`=0, `data_out`=0xFF, `done_flag` still pulses.
- 3·DIV-cycle low glitch on the idle line (baud 00) -> return to IDLE after the start sample; no `done_flag`; `active_flag` drops.
- Assert `reset` mid-DATA of a 0x5A frame, release, then send 0x3C -> all outputs 0 after reset; only 0x3C is delivered, with one `done_flag`.

Source files
------------

// File: rtl/uart_rx_unit.sv
// UART receiver: 16x oversampled, mid-bit sampling, optional odd/even parity, one-cycle done pulse.
// Define UART_RX_SYNC2_EN for a two-flop input synchronizer (default: single register stage).
module uart_rx_unit #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       active_flag,
    output logic       done_flag,
    output logic       parity_error,
    output logic       frame_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [15:0] DIV_M1_2400  = 16'(CLK_FREQ / (16 * 2400) - 1);
    localparam logic [15:0] DIV_M1_4800  = 16'(CLK_FREQ / (16 * 4800) - 1);
    localparam logic [15:0] DIV_M1_9600  = 16'(CLK_FREQ / (16 * 9600) - 1);
    localparam logic [15:0] DIV_M1_19200 = 16'(CLK_FREQ / (16 * 19200) - 1);

    logic        rx_s_q;
    logic        rx_prev_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  nib_q, nib_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  baud_q, baud_d;
    logic [1:0]  par_q, par_d;
    logic        perr_pend_q, perr_pend_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;

    logic [15:0] div_m1;
    logic        tick;
    logic        start_edge;
    logic        par_en;
    logic        mid_bit;

`ifdef UART_RX_SYNC2_EN
    logic rx_meta_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= data_rx;
            rx_s_q    <= rx_meta_q;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s_q <= 1'b1;
        end else begin
            rx_s_q <= data_rx;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_edge = rx_prev_q & ~rx_s_q;
    assign par_en     = (par_q == 2'b01) || (par_q == 2'b10);

    always_comb begin
        case (baud_q)
            2'b00:   div_m1 = DIV_M1_2400;
            2'b01:   div_m1 = DIV_M1_4800;
            2'b10:   div_m1 = DIV_M1_9600;
            default: div_m1 = DIV_M1_19200;
        endcase
    end

    assign tick    = (state_q != S_IDLE) && (cnt_q == div_m1);
    assign mid_bit = tick && (nib_q == 4'd15);

    // The tick-count nibble wraps every 16 ticks, so each full-bit wait ends at nibble 15.
    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? 16'd0 : cnt_q + 16'd1;
        nib_d       = tick ? nib_q + 4'd1 : nib_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        par_d       = par_q;
        perr_pend_d = perr_pend_q;
        data_out_d  = data_out_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                nib_d = 4'd0;
                if (start_edge) begin
                    state_d     = S_START;
                    baud_d      = baud_rate;
                    par_d       = parity_type;
                    bit_d       = 3'd0;
                    perr_pend_d = 1'b0;
                end
            end
            S_START: begin
                if (tick && (nib_q == 4'd7)) begin
                    nib_d   = 4'd0;
                    bit_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (mid_bit) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (mid_bit) begin
                    perr_pend_d = (^shift_q) ^ rx_s_q ^ (par_q == 2'b01);
                    state_d     = S_STOP;
                end
            end
            S_STOP: begin
                if (mid_bit) begin
                    state_d    = S_DONE;
                    data_out_d = shift_q;
                    perr_d     = par_en & perr_pend_q;
                    ferr_d     = ~rx_s_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                nib_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                nib_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            nib_q       <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            baud_q      <= 2'b00;
            par_q       <= 2'b00;
            perr_pend_q <= 1'b0;
            data_out_q  <= 8'd0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nib_q       <= nib_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            par_q       <= par_d;
            perr_pend_q <= perr_pend_d;
            data_out_q  <= data_out_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_out     = data_out_q;
    assign active_flag  = (state_q != S_IDLE);
    assign done_flag    = (state_q == S_DONE);
    assign parity_error = perr_q;
    assign frame_error  = ferr_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Bench for uart_rx_unit: directed frames, expected results queued by the driver and
// matched by an independent monitor on every done_flag pulse.
module tb_uart_rx_unit;

    localparam int CLK_FREQ = 614_400;
`ifdef UART_RX_SYNC2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic       data_rx;
    logic [7:0] data_out;
    logic       active_flag;
    logic       done_flag;
    logic       parity_error;
    logic       frame_error;

    uart_rx_unit #(.CLK_FREQ(CLK_FREQ)) dut (
        .clock        (clock),
        .reset        (reset),
        .parity_type  (parity_type),
        .baud_rate    (baud_rate),
        .data_rx      (data_rx),
        .data_out     (data_out),
        .active_flag  (active_flag),
        .done_flag    (done_flag),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int dones  = 0;
    // Entry layout: [41:10] done cycle, [9] frame_error, [8] parity_error, [7:0] data.
    logic [41:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic drive_bit(input logic v, input int div);
        data_rx = v;
        repeat (16 * div) @(negedge clock);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'h00);
        check({tag, "_active"},   32'(active_flag), 32'd0);
        check({tag, "_done"},     32'(done_flag), 32'd0);
        check({tag, "_perr"},     32'(parity_error), 32'd0);
        check({tag, "_ferr"},     32'(frame_error), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] baud, input logic [1:0] par,
                              input logic par_bit, input logic stop_bit, input logic exp_perr);
        int div;
        int e;
        int done_cyc;
        logic has_par;
        div         = 16 >> baud;
        has_par     = (par == 2'b01) || (par == 2'b10);
        baud_rate   = baud;
        parity_type = par;
        @(negedge clock);
        e        = cyc + LAT;
        done_cyc = e + (has_par ? 168 : 152) * div + 1;
        exp_q.push_back({32'(done_cyc), ~stop_bit, exp_perr, d});
        drive_bit(1'b0, div);
        for (int i = 0; i < 8; i++) drive_bit(d[i], div);
        if (has_par) drive_bit(par_bit, div);
        drive_bit(stop_bit, div);
        data_rx = 1'b1;
        wait_cycles(20);
    endtask

    initial begin : monitor
        logic        prev_done;
        logic [41:0] ent;
        prev_done = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (prev_done) check("active_fall", 32'(active_flag), 32'd0);
            if (done_flag === 1'b1) begin
                dones++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got data %0h expected no frame", data_out);
                end else begin
                    ent = exp_q.pop_front();
                    check("data_out",     32'(data_out), 32'(ent[7:0]));
                    check("parity_error", 32'(parity_error), 32'(ent[8]));
                    check("frame_error",  32'(frame_error), 32'(ent[9]));
                    check("done_cycle",   32'(cyc), ent[41:10]);
                    check("active_at_done", 32'(active_flag), 32'd1);
                end
            end
            prev_done = (done_flag === 1'b1);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within 2ms");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int e;
        reset       = 1'b1;
        data_rx     = 1'b1;
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        wait_cycles(5);
        check_idle_outputs("reset");
        reset = 1'b0;

        wait_cycles(1000);
        check_idle_outputs("idle");
        check("idle_no_done", 32'(dones), 32'd0);

        send_frame(8'hA5, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        send_frame(8'h03, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
        send_frame(8'h03, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
        check("held_data_out", 32'(data_out), 32'hFF);
        check("held_ferr", 32'(frame_error), 32'd1);

        // Short low glitch: rejected at the start sample (tick 8, 128 clocks at DIV 16).
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        @(negedge clock);
        data_rx = 1'b0;
        e = cyc + LAT;
        repeat (48) @(negedge clock);
        data_rx = 1'b1;
        wait_until(e + 64);
        check("glitch_active_mid", 32'(active_flag), 32'd1);
        wait_until(e + 128);
        check("glitch_active_at_sample", 32'(active_flag), 32'd1);
        wait_until(e + 129);
        check("glitch_active_after", 32'(active_flag), 32'd0);
        check("glitch_ferr_kept", 32'(frame_error), 32'd1);
        check("glitch_data_kept", 32'(data_out), 32'hFF);
        wait_cycles(50);

        // Reset in the middle of a 0x5A frame at DIV 4; that frame must never be delivered.
        baud_rate   = 2'b10;
        parity_type = 2'b00;
        @(negedge clock);
        drive_bit(1'b0, 4);
        for (int i = 0; i < 3; i++) drive_bit(1'(8'h5A >> i), 4);
        check("midframe_active", 32'(active_flag), 32'd1);
        reset   = 1'b1;
        data_rx = 1'b1;
        wait_cycles(3);
        check_idle_outputs("midreset");
        reset = 1'b0;
        wait_cycles(40);
        check_idle_outputs("postreset");
        send_frame(8'h3C, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);

        wait_cycles(100);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(dones), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
